// File: rtl/imm_extend_unit.sv
// -----------------------------------------------------------------------------
// imm_extend_unit
//
// Pipelined immediate extender for the decode stage. Each accepted beat is
// extended combinationally (sign / zero / upper / branch-offset) and registered
// into the main output stage M. A skid stage S holds one more beat so that a
// stall on the output side never drops or duplicates an immediate.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   in_valid    input beat present
//   in_ready    block can accept a beat (registered, !S_valid)
//   in_imm      raw immediate field [IN_W-1:0]
//   in_mode     00 sign, 01 zero, 10 upper, 11 branch
//   in_tag      sideband tag, passed through unchanged
//   out_valid   extended result present (M valid)
//   out_ready   consumer accepts result this cycle
//   out_data    extended immediate [OUT_W-1:0]
//   out_tag     tag of the beat on out_data
//   out_neg     copy of out_data[OUT_W-1]
//   xfer_count  completed output handshakes, wrapping
// -----------------------------------------------------------------------------
module imm_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_neg,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int E = OUT_W - IN_W;

    // Encoding chosen so bit 0 is "M valid" and bit 1 is "S valid"; the
    // handshake outputs are then plain register bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [OUT_W-1:0]   r_m_data;
    logic [TAG_W-1:0]   r_m_tag;
    logic               r_m_neg;
    logic [OUT_W-1:0]   r_s_data;
    logic [TAG_W-1:0]   r_s_tag;
    logic               r_s_neg;
    logic [CNT_W-1:0]   r_count;

    logic [OUT_W-1:0]   w_ext;
    logic               w_accept;
    logic               w_xfer;
    logic               w_load_m_in;
    logic               w_load_m_s;
    logic               w_load_s_in;

    // Branch mode shifts the sign-extended value left by two; its top two
    // bits fall off the end.
    function automatic logic [OUT_W-1:0] extend_imm(input logic [IN_W-1:0] imm,
                                                    input logic [1:0]      mode);
        logic [OUT_W-1:0] sext;
        sext = {{E{imm[IN_W-1]}}, imm};
        case (mode)
            2'b00:   extend_imm = sext;
            2'b01:   extend_imm = {{E{1'b0}}, imm};
            2'b10:   extend_imm = {imm, {E{1'b0}}};
            2'b11:   extend_imm = {sext[OUT_W-3:0], 2'b00};
            default: extend_imm = sext;
        endcase
    endfunction

    assign w_ext      = extend_imm(in_imm, in_mode);
    assign out_valid  = r_state[0];
    assign in_ready   = ~r_state[1];
    assign w_accept   = in_valid & in_ready;
    assign w_xfer     = out_valid & out_ready;
    assign out_data   = r_m_data;
    assign out_tag    = r_m_tag;
    assign out_neg    = r_m_neg;
    assign xfer_count = r_count;

    // Buffer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and stage-load decode.
    always_comb begin
        w_next_state = r_state;
        w_load_m_in  = 1'b0;
        w_load_m_s   = 1'b0;
        w_load_s_in  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state = ST_ONE;
                    w_load_m_in  = 1'b1;
                end else begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (w_accept && w_xfer) begin
                    w_next_state = ST_ONE;
                    w_load_m_in  = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_FULL;
                    w_load_s_in  = 1'b1;
                end else if (w_xfer) begin
                    w_next_state = ST_EMPTY;
                end else begin
                    w_next_state = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so nothing new can arrive.
                if (w_xfer) begin
                    w_next_state = ST_ONE;
                    w_load_m_s   = 1'b1;
                end else begin
                    w_next_state = ST_FULL;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    // Main output stage M: loads a fresh beat or the skid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_data <= {OUT_W{1'b0}};
            r_m_tag  <= {TAG_W{1'b0}};
            r_m_neg  <= 1'b0;
        end else if (w_load_m_in) begin
            r_m_data <= w_ext;
            r_m_tag  <= in_tag;
            r_m_neg  <= w_ext[OUT_W-1];
        end else if (w_load_m_s) begin
            r_m_data <= r_s_data;
            r_m_tag  <= r_s_tag;
            r_m_neg  <= r_s_neg;
        end
    end

    // Skid stage S: captures a beat accepted while M is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_data <= {OUT_W{1'b0}};
            r_s_tag  <= {TAG_W{1'b0}};
            r_s_neg  <= 1'b0;
        end else if (w_load_s_in) begin
            r_s_data <= w_ext;
            r_s_tag  <= in_tag;
            r_s_neg  <= w_ext[OUT_W-1];
        end
    end

    // Output handshake counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= {CNT_W{1'b0}};
        end else if (w_xfer) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_extend_unit.sv
module tb_imm_extend_unit;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_neg;
    logic [15:0] xfer_count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [11:0] s_in_imm;
    logic [1:0]  s_in_mode;
    logic [4:0]  s_in_tag;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [23:0] s_out_data;
    logic [4:0]  s_out_tag;
    logic        s_out_neg;
    logic [1:0]  s_xfer_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    imm_extend_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_imm     (in_imm),
        .in_mode    (in_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_neg    (out_neg),
        .xfer_count (xfer_count)
    );

    imm_extend_unit #(.IN_W(12), .OUT_W(24), .TAG_W(5), .CNT_W(2)) u_small (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_imm     (s_in_imm),
        .in_mode    (s_in_mode),
        .in_tag     (s_in_tag),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_data   (s_out_data),
        .out_tag    (s_out_tag),
        .out_neg    (s_out_neg),
        .xfer_count (s_xfer_count)
    );

    task automatic do_reset();
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_imm      = 16'h0;
        in_mode     = 2'b00;
        in_tag      = 5'd0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_in_imm    = 12'h0;
        s_in_mode   = 2'b00;
        s_in_tag    = 5'd0;
        s_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
            out_tag !== 5'd0 || out_neg !== 1'b0 || xfer_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state got valid=%b ready=%b data=%h tag=%h neg=%b cnt=%0d expected 0 1 0 0 0 0",
                     out_valid, in_ready, out_data, out_tag, out_neg, xfer_count);
        end
        checks++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1 || s_out_data !== 24'h0 || s_xfer_count !== 2'd0) begin
            failures++;
            $display("FAIL reset_small got valid=%b ready=%b data=%h cnt=%0d expected 0 1 0 0",
                     s_out_valid, s_in_ready, s_out_data, s_xfer_count);
        end
    endtask

    task automatic test_sign_stream();
        logic [15:0] imm_v [4];
        logic [31:0] exp_v [4];
        logic        neg_v [4];
        imm_v = '{16'h000F, 16'h007F, 16'h8000, 16'hFFFF};
        exp_v = '{32'h0000000F, 32'h0000007F, 32'hFFFF8000, 32'hFFFFFFFF};
        neg_v = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'b00;
            in_imm   = imm_v[i];
            in_tag   = 5'(i + 1);
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[i] || out_neg !== neg_v[i] || out_tag !== 5'(i + 1)) begin
                failures++;
                $display("FAIL sign_beat%0d got valid=%b data=%h neg=%b tag=%0d expected 1 %h %b %0d",
                         i, out_valid, out_data, out_neg, out_tag, exp_v[i], neg_v[i], i + 1);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || xfer_count !== 16'd4) begin
            failures++;
            $display("FAIL sign_drain got valid=%b cnt=%0d expected 0 4", out_valid, xfer_count);
        end
    endtask

    task automatic test_mode_sweep();
        logic [1:0]  mode_v [4];
        logic [31:0] exp_v  [4];
        mode_v = '{2'b01, 2'b10, 2'b11, 2'b00};
        exp_v  = '{32'h00008001, 32'h80010000, 32'hFFFE0004, 32'hFFFF8001};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_mode  = mode_v[i];
            in_imm   = 16'h8001;
            in_tag   = 5'd0;
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_v[i] || out_neg !== exp_v[i][31]) begin
                failures++;
                $display("FAIL mode_sweep%0d got valid=%b data=%h neg=%b expected 1 %h %b",
                         i, out_valid, out_data, out_neg, exp_v[i], exp_v[i][31]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_branch_tags();
        logic [15:0] imm_v [4];
        logic [31:0] exp_v [4];
        imm_v = '{16'hFFFF, 16'h0001, 16'h4000, 16'h8000};
        exp_v = '{32'hFFFFFFFC, 32'h00000004, 32'h00010000, 32'hFFFE0000};
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_mode  = 2'b11;
            in_imm   = imm_v[i];
            in_tag   = 5'(i + 1);
            @(posedge clk);
            #1;
            checks++;
            if (out_data !== exp_v[i] || out_tag !== 5'(i + 1)) begin
                failures++;
                $display("FAIL branch_beat%0d got data=%h tag=%0d expected %h %0d",
                         i, out_data, out_tag, exp_v[i], i + 1);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [15:0] imm_v [4];
        logic [31:0] exp_v [4];
        int          idx;
        int          nout;
        logic        acc;
        imm_v = '{16'h0001, 16'h8000, 16'h7FFF, 16'hFFFE};
        exp_v = '{32'h00000001, 32'hFFFF8000, 32'h00007FFF, 32'hFFFFFFFE};
        do_reset();
        idx  = 0;
        nout = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 40 && nout < 4; cyc++) begin
            if (cyc == 5) out_ready = 1'b1;
            in_valid = (idx < 4);
            in_mode  = 2'b00;
            in_imm   = imm_v[(idx < 4) ? idx : 3];
            in_tag   = 5'(idx + 1);
            acc      = in_valid && in_ready;
            if (out_valid && out_ready) begin
                checks++;
                if (out_tag !== 5'(nout + 1) || out_data !== exp_v[nout]) begin
                    failures++;
                    $display("FAIL bp_order%0d got tag=%0d data=%h expected %0d %h",
                             nout, out_tag, out_data, nout + 1, exp_v[nout]);
                end
                nout++;
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (cyc == 1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_ready_low got in_ready=%b expected 0", in_ready);
                end
            end
            if (cyc >= 2 && cyc <= 4) begin
                checks++;
                if (out_valid !== 1'b1 || out_tag !== 5'd1 || out_data !== exp_v[0] || idx != 2) begin
                    failures++;
                    $display("FAIL bp_hold%0d got valid=%b tag=%0d data=%h accepted=%0d expected 1 1 %h 2",
                             cyc, out_valid, out_tag, out_data, idx, exp_v[0]);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (nout != 4 || in_ready !== 1'b1 || out_valid !== 1'b0 || xfer_count !== 16'd4) begin
            failures++;
            $display("FAIL bp_recover got beats=%0d in_ready=%b valid=%b cnt=%0d expected 4 1 0 4",
                     nout, in_ready, out_valid, xfer_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_imm    = 16'h8000;
        in_tag    = 5'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 5'd9;
        @(posedge clk);
        #1;
        in_imm = 16'hFFFF;
        in_tag = 5'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'hFFFF8000 || out_tag !== 5'd9 || xfer_count !== 16'd1) begin
            failures++;
            $display("FAIL mid_full got in_ready=%b data=%h tag=%0d cnt=%0d expected 0 ffff8000 9 1",
                     in_ready, out_data, out_tag, xfer_count);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'd0 || out_neg !== 1'b0 ||
            xfer_count !== 16'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_async_reset got valid=%b data=%h tag=%0d neg=%b cnt=%0d ready=%b expected 0 0 0 0 0 1",
                     out_valid, out_data, out_tag, out_neg, xfer_count, in_ready);
        end
        #2;
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'b00;
        in_imm    = 16'h0001;
        in_tag    = 5'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000001 || out_tag !== 5'd3) begin
            failures++;
            $display("FAIL mid_after_beat got valid=%b data=%h tag=%0d expected 1 00000001 3",
                     out_valid, out_data, out_tag);
        end
        @(posedge clk);
        #1;
        checks++;
        if (xfer_count !== 16'd1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_after_count got cnt=%0d valid=%b expected 1 0", xfer_count, out_valid);
        end
    endtask

    task automatic test_param_small();
        logic [1:0]  mode_v [5];
        logic [11:0] imm_v  [5];
        logic [23:0] exp_v  [5];
        logic        neg_v  [5];
        mode_v = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00};
        imm_v  = '{12'h800, 12'h123, 12'hABC, 12'h801, 12'h7FF};
        exp_v  = '{24'hFFF800, 24'h123000, 24'h000ABC, 24'hFFE004, 24'h0007FF};
        neg_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        s_out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_in_valid = 1'b1;
            s_in_mode  = mode_v[i];
            s_in_imm   = imm_v[i];
            s_in_tag   = 5'(i);
            @(posedge clk);
            #1;
            checks++;
            if (s_out_valid !== 1'b1 || s_out_data !== exp_v[i] || s_out_neg !== neg_v[i]) begin
                failures++;
                $display("FAIL small_beat%0d got valid=%b data=%h neg=%b expected 1 %h %b",
                         i, s_out_valid, s_out_data, s_out_neg, exp_v[i], neg_v[i]);
            end
        end
        s_in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (s_xfer_count !== 2'd1 || s_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL small_wrap got cnt=%0d valid=%b expected 1 0", s_xfer_count, s_out_valid);
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_sign_stream();
        test_mode_sweep();
        test_branch_tags();
        test_backpressure();
        test_reset_mid();
        test_param_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, pipelined immediate extender for the decode stage of the Phase1 datapath. It generalises plain 16→32 sign extension to configurable widths and four extension modes: sign, zero, upper-load and branch-offset. The block sits between instruction decode and the ALU operand mux. A valid/ready handshake on both sides and a 2-entry skid buffer let decode stalls propagate without losing or duplicating immediates.

## Interface
- IN_W, 16, immediate input width (≥2)
- OUT_W, 32, extended output width (> IN_W + 2)
- TAG_W, 5, sideband tag carried with each immediate (e.g. destination register)
- CNT_W, 16, width of transfer counter
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous and active-high
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat this cycle
- in_imm  input  IN_W  raw immediate field
- in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch
- in_tag  input  TAG_W  sideband, passed through unchanged
- out_valid  output  1  extended result present
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  OUT_W  extended immediate
- out_tag  output  TAG_W  tag of the beat on out_data
- out_neg  output  1  out_data[OUT_W-1]
- xfer_count  output  CNT_W  number of completed output handshakes, wrapping

## Operation
- Mode arithmetic, with E = OUT_W − IN_W:
  - sign: out = {E copies of imm[IN_W-1], imm}
  - zero: out = {E zeros, imm}
  - upper: out = imm << E, low E bits zero
  - branch: out = (sign-extended imm) << 2; the top 2 bits of the sign-extended value are discarded
- Extension is computed combinationally on input. The result, tag and neg flag are registered into the main output register (stage M).
- A skid register (stage S) holds one extra beat.
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Buffer states:
  - EMPTY: M invalid, S invalid
  - ONE: M valid, S invalid
  - FULL: M valid, S valid
- Transitions:
  - EMPTY + accept → ONE
  - ONE + accept + no transfer → FULL (new beat into S)
  - ONE + accept + transfer → ONE (new beat into M)
  - ONE + transfer only → EMPTY
  - FULL + transfer → ONE (S moves to M)
  - FULL + no transfer → FULL (hold)
- in_ready = !S_valid. It is a registered state bit with no combinational path from out_ready.
- Simultaneous accept and transfer in ONE is legal and keeps occupancy 1.
- Beats leave strictly in accept order. No beat is ever dropped or duplicated.
- out_data, out_tag and out_neg are stable while out_valid && !out_ready.
- xfer_count increments by 1 on each transfer and wraps from 2^CNT_W−1 to 0.
- Reset, at any time including mid-transfer:
  - out_valid=0, S invalid, in_ready=1
  - out_data=0, out_tag=0, out_neg=0, xfer_count=0
  - In-flight beats are discarded.

## Timing
- Latency: a beat accepted at edge N presents out_valid=1 with its data after edge N (visible in cycle N+1) when M is empty or transferring.
- Throughput: 1 beat/cycle with out_ready held high.
- Backpressure: with out_ready=0, the block accepts at most 2 beats. in_ready goes low the cycle after the second accept.
- Recovery: after out_ready returns to 1, in_ready rises the cycle after the first transfer out of FULL.
- Reset is asynchronous assert. Outputs take their reset values immediately, without waiting for a clock edge.
- First accept is possible on the first rising edge after rst deasserts.

## Test plan
- Sign mode, out_ready=1. Inputs 0x000F, 0x007F, 0x8000, 0xFFFF on consecutive cycles → 0x0000000F, 0x0000007F, 0xFFFF8000, 0xFFFFFFFF one cycle later, back-to-back. out_neg=0,0,1,1. xfer_count=4.
- Mode sweep on imm=0x8001:
  - zero → 0x00008001
  - upper → 0x80010000
  - branch → 0xFFFE0004
  - sign → 0xFFFF8001
- Branch mode on imm=0xFFFF → 0xFFFFFFFC. Tags 1..4 appear in order on out_tag.
- Backpressure: out_ready=0, drive 4 valid beats (tags 1..4) → only tags 1,2 accepted and in_ready=0. Hold 3 cycles: out_data and out_tag stay at tag 1. Then out_ready=1 → tags 1,2,3,4 emerge in order with none lost, and in_ready returns to 1.
- Reset mid-operation: assert rst while FULL → out_valid, out_data, xfer_count go to 0 and in_ready=1 without a clock edge. After release, one sign beat 0x0001 → 0x00000001 and xfer_count=1.
- Parameter instance IN_W=12, OUT_W=24, CNT_W=2: sign 0x800 → 0xFFF800, upper 0x123 → 0x123000. Five transfers → xfer_count wraps to 1.
